lsu: RTL and testbench

- Load/store unit: the execute-side consumer of the main decoder's memory controls (mem_rd, mem_wr, mask) plus the ALU address and rs2 data.
- Turns one load or store into a single request/acknowledge transaction on the data-memory bus.
- Stalls the pipeline while the transaction is outstanding.
- Returns byte-aligned, sign- or zero-extended load data for the sel_wb=0 writeback path.

---
 rtl/lsu.sv | 247 ++++++++++++++++++++++++
 tb/tb_lsu.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit
//
// Converts one decoded load or store into a single request/acknowledge
// transaction on the data-memory bus. The pipeline is stalled while the
// transaction is outstanding. Loads return byte-aligned data that is sign- or
// zero-extended for the writeback path.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   mem_rd_i         load request from the decoder
//   mem_wr_i         store request from the decoder
//   mask_i           funct3 size code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr_i           effective byte address from the ALU
//   wdata_i          store data (rs2)
//   stall_o          hold the pipeline
//   rdata_o          aligned and extended load result (held until next load)
//   rdata_valid_o    one-cycle pulse when rdata_o was just updated
//   exc_o            one-cycle exception pulse
//   exc_code_o       01 misaligned, 10 illegal, 11 bus timeout, 00 otherwise
//   bus_req_o        bus transaction request
//   bus_we_o         bus write enable
//   bus_addr_o       word-aligned bus address
//   bus_be_o         bus byte enables
//   bus_wdata_o      lane-replicated store data
//   bus_ack_i        transaction complete (one-cycle pulse)
//   bus_rdata_i      read word, valid together with bus_ack_i
// -----------------------------------------------------------------------------
module lsu #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  mask_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        exc_o,
    output logic [1:0]  exc_code_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  wait_cnt;

    logic        lat_we;
    logic [2:0]  lat_mask;
    logic [1:0]  lat_off;
    logic [31:0] lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic [31:0] rdata_q;

    logic        access;
    logic        illegal;
    logic        misaligned;
    logic        valid_access;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] load_shifted;
    logic [31:0] load_data;

    // Classify the request presented in IDLE. An illegal encoding takes
    // priority over misalignment so each request reports exactly one cause.
    always_comb begin
        access     = mem_rd_i | mem_wr_i;
        illegal    = access && ((mem_rd_i && mem_wr_i) ||
                                (mask_i == 3'b011) || (mask_i == 3'b110) ||
                                (mask_i == 3'b111) || (mem_wr_i && mask_i[2]));
        misaligned = access && !illegal &&
                     (((mask_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((mask_i == 3'b010) && (addr_i[1:0] != 2'b00)));
        valid_access = access && !illegal && !misaligned;
    end

    // Byte enables and lane-replicated data for the bus. Replicating the
    // store data lets the memory pick its lanes purely from the byte enables.
    // Loads always fetch the full word and extract the field on return.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = wdata_i;
        if (mem_wr_i) begin
            case (mask_i[1:0])
                2'b00: begin
                    store_be    = 4'b0001 << addr_i[1:0];
                    store_wdata = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    store_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                    store_wdata = {2{wdata_i[15:0]}};
                end
                default: begin
                    store_be    = 4'b1111;
                    store_wdata = wdata_i;
                end
            endcase
        end
    end

    // Shift the addressed field down to bit 0, then extend it according to
    // the latched size code.
    always_comb begin
        load_shifted = bus_rdata_i >> {lat_off, 3'b000};
        case (lat_mask)
            3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_data = {24'd0, load_shifted[7:0]};
            3'b101:  load_data = {16'd0, load_shifted[15:0]};
            default: load_data = load_shifted;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. In BUSY an acknowledge beats the timeout when both
    // happen in the same cycle. RESP and ERR last exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (valid_access) next_state = BUSY;
            BUSY: begin
                if (bus_ack_i) begin
                    next_state = RESP;
                end else if (wait_cnt == LAST_WAIT) begin
                    next_state = ERR;
                end
            end
            RESP:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic. Outputs are forced low while reset is held so the bus
    // request and the stall disappear immediately, even mid-transaction.
    always_comb begin
        stall_o       = 1'b0;
        rdata_valid_o = 1'b0;
        exc_o         = 1'b0;
        exc_code_o    = 2'b00;
        bus_req_o     = 1'b0;
        bus_we_o      = 1'b0;
        bus_addr_o    = 32'd0;
        bus_be_o      = 4'd0;
        bus_wdata_o   = 32'd0;
        rdata_o       = rdata_q;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    stall_o = valid_access;
                    if (illegal) begin
                        exc_o      = 1'b1;
                        exc_code_o = 2'b10;
                    end else if (misaligned) begin
                        exc_o      = 1'b1;
                        exc_code_o = 2'b01;
                    end
                end
                BUSY: begin
                    stall_o     = 1'b1;
                    bus_req_o   = 1'b1;
                    bus_we_o    = lat_we;
                    bus_addr_o  = lat_addr;
                    bus_be_o    = lat_be;
                    bus_wdata_o = lat_wdata;
                end
                RESP: begin
                    rdata_valid_o = !lat_we;
                end
                ERR: begin
                    exc_o      = 1'b1;
                    exc_code_o = 2'b11;
                end
                default: begin
                    stall_o = 1'b0;
                end
            endcase
        end
    end

    // Transaction datapath: capture the request on acceptance so the bus sees
    // constant values for the whole BUSY interval, count wait cycles, and
    // capture the extended load result on the acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= 8'd0;
            lat_we    <= 1'b0;
            lat_mask  <= 3'd0;
            lat_off   <= 2'd0;
            lat_addr  <= 32'd0;
            lat_be    <= 4'd0;
            lat_wdata <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (valid_access) begin
                        lat_we    <= mem_wr_i;
                        lat_mask  <= mask_i;
                        lat_off   <= addr_i[1:0];
                        lat_addr  <= {addr_i[31:2], 2'b00};
                        lat_be    <= store_be;
                        lat_wdata <= store_wdata;
                    end
                end
                BUSY: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (bus_ack_i && !lat_we) begin
                        rdata_q <= load_data;
                    end
                end
                default: begin
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- testbench for lsu
//
// Table of directed single-transaction vectors with hand-computed results,
// followed by hand-written sequences for timeout, late acknowledge,
// mid-transaction reset and stray acknowledges.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [2:0]  mask_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        exc_o;
    logic [1:0]  exc_code_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int errors;
    int checks;
    logic [31:0] model_rdata;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] bus_rdata;
        logic [1:0]  exp_exc;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    lsu #(.MAX_WAIT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_rd_i      (mem_rd_i),
        .mem_wr_i      (mem_wr_i),
        .mask_i        (mask_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .exc_o         (exc_o),
        .exc_code_o    (exc_code_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_be_o      (bus_be_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i   (bus_rdata_i)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request to the unit; the caller sits just after a negedge.
    task automatic apply_stimulus(input logic rd, input logic wr,
                                  input logic [2:0] mask,
                                  input logic [31:0] addr,
                                  input logic [31:0] wdata);
        mem_rd_i = rd;
        mem_wr_i = wr;
        mask_i   = mask;
        addr_i   = addr;
        wdata_i  = wdata;
    endtask

    // Drive one vector through the unit from the request cycle to the next
    // idle cycle, checking every cycle along the way.
    task automatic run_vec(input vec_t v);
        apply_stimulus(v.rd, v.wr, v.mask, v.addr, v.wdata);
        #1;
        if (v.exp_exc != 2'b00) begin
            check_output("exc_pulse", exc_o, 1'b1);
            check_output("exc_code", exc_code_o, v.exp_exc);
            check_output("exc_stall", stall_o, 1'b0);
            check_output("exc_req", bus_req_o, 1'b0);
            @(negedge clk);
            apply_stimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
            #1;
            check_output("exc_one_cycle", exc_o, 1'b0);
            check_output("exc_state_idle", bus_req_o, 1'b0);
            @(negedge clk);
        end else begin
            check_output("req_stall", stall_o, 1'b1);
            check_output("req_no_exc", exc_o, 1'b0);
            @(negedge clk);
            for (int k = 1; k <= v.ack_dly; k++) begin
                bus_ack_i   = (k == v.ack_dly);
                bus_rdata_i = (k == v.ack_dly) ? v.bus_rdata : 32'hA5A5_5A5A;
                #1;
                check_output("busy_req", bus_req_o, 1'b1);
                check_output("busy_stall", stall_o, 1'b1);
                check_output("busy_we", bus_we_o, v.wr);
                check_output("busy_addr", bus_addr_o, v.exp_addr);
                check_output("busy_be", bus_be_o, v.exp_be);
                if (v.wr) check_output("busy_wdata", bus_wdata_o, v.exp_wdata);
                @(negedge clk);
            end
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'd0;
            if (v.rd) model_rdata = v.exp_rdata;
            #1;
            check_output("resp_req", bus_req_o, 1'b0);
            check_output("resp_stall", stall_o, 1'b0);
            check_output("resp_valid", rdata_valid_o, v.rd);
            check_output("resp_rdata", rdata_o, model_rdata);
            check_output("resp_no_exc", exc_o, 1'b0);
            @(negedge clk);
            apply_stimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
            #1;
            check_output("idle_stall", stall_o, 1'b0);
            check_output("idle_valid", rdata_valid_o, 1'b0);
            check_output("idle_rdata_hold", rdata_o, model_rdata);
            @(negedge clk);
        end
    endtask

    // Load with no acknowledge (timeout) or with the acknowledge arriving on
    // the last permitted BUSY cycle.
    task automatic run_timeout(input bit do_ack);
        int  req_cnt;
        bit  done;
        req_cnt = 0;
        done    = 1'b0;
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0);
        #1;
        check_output("to_req_stall", stall_o, 1'b1);
        @(negedge clk);
        for (int c = 0; c < 40 && !done; c++) begin
            bus_ack_i   = do_ack && (req_cnt == 15);
            bus_rdata_i = 32'h0BAD_F00D;
            #1;
            if (bus_req_o) begin
                req_cnt++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        bus_ack_i = 1'b0;
        check_output("to_bound", done, 1'b1);
        check_output("to_req_cycles", req_cnt, 32'd16);
        if (!do_ack) begin
            check_output("to_exc", exc_o, 1'b1);
            check_output("to_code", exc_code_o, 2'b11);
            check_output("to_stall", stall_o, 1'b0);
            check_output("to_no_valid", rdata_valid_o, 1'b0);
            check_output("to_rdata_hold", rdata_o, model_rdata);
        end else begin
            model_rdata = 32'h0BAD_F00D;
            check_output("late_no_exc", exc_o, 1'b0);
            check_output("late_valid", rdata_valid_o, 1'b1);
            check_output("late_rdata", rdata_o, model_rdata);
        end
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        #1;
        check_output("to_after_exc", exc_o, 1'b0);
        check_output("to_after_stall", stall_o, 1'b0);
        check_output("to_after_req", bus_req_o, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        model_rdata = 32'd0;
        rst_n       = 1'b0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;
        apply_stimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

        //          rd    wr    mask    addr          wdata         dly bus_rdata     exc    exp_addr      be       exp_wdata     exp_rdata
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,       3, 32'hDEAD_BEEF, 2'b00, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,       1, 32'h80FF_0000, 2'b00, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,       1, 32'h80FF_0000, 2'b00, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0202, 32'h1234_5678, 2, 32'h0,       2'b00, 32'h0000_0200, 4'b0100, 32'h7878_7878, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_5678, 1, 32'h0,       2'b00, 32'h0000_0200, 4'b1100, 32'h5678_5678, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,       0, 32'h0,         2'b01, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[6]  = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,       0, 32'h0,         2'b10, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,       2, 32'hABCD_0000, 2'b00, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_ABCD};
        vecs[8]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,       1, 32'hABCD_0000, 2'b00, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_ABCD};
        vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 1, 32'h0,       2'b00, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 1, 32'h0,       2'b00, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h0000_0300, 32'h0,       0, 32'h0,         2'b10, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h0000_0302, 32'h0,       0, 32'h0,         2'b01, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b1, 1'b0, 3'b011, 32'h0000_0300, 32'h0,       0, 32'h0,         2'b10, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,       1, 32'h1234_567F, 2'b00, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_007F};
        vecs[15] = '{1'b0, 1'b1, 3'b001, 32'h0000_0300, 32'hFFFF_BEEF, 1, 32'h0,       2'b00, 32'h0000_0300, 4'b0011, 32'hBEEF_BEEF, 32'h0};

        // Reset state.
        @(negedge clk);
        #1;
        check_output("rst_stall", stall_o, 1'b0);
        check_output("rst_req", bus_req_o, 1'b0);
        check_output("rst_rdata", rdata_o, 32'd0);
        check_output("rst_valid", rdata_valid_o, 1'b0);
        check_output("rst_exc", exc_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        run_timeout(1'b0);
        run_timeout(1'b1);

        // Stray acknowledge in IDLE must not change anything.
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h5555_5555;
        #1;
        check_output("stray_stall", stall_o, 1'b0);
        @(negedge clk);
        bus_ack_i = 1'b0;
        #1;
        check_output("stray_valid", rdata_valid_o, 1'b0);
        check_output("stray_rdata", rdata_o, model_rdata);
        @(negedge clk);

        // Reset asserted on the second BUSY cycle of a load.
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0);
        @(negedge clk);
        #1;
        check_output("mid_busy1_req", bus_req_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_req", bus_req_o, 1'b0);
        check_output("mid_rst_stall", stall_o, 1'b0);
        check_output("mid_rst_rdata", rdata_o, 32'd0);
        model_rdata = 32'd0;
        apply_stimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("post_rst_req", bus_req_o, 1'b0);
        check_output("post_rst_stall", stall_o, 1'b0);
        @(negedge clk);
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
